// File: rtl/pipe_pkg.sv
// Shared types and constants for the inter-stage pipeline register.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_pkg;

    // Occupancy of a stage: nothing held, main slot only, main plus skid slot.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    // Default bundle widths for each stage boundary.
    localparam int IF_ID_DATA_W   = 64;
    localparam int IF_ID_CTRL_W   = 5;
    localparam int ID_EX_DATA_W   = 97;
    localparam int ID_EX_CTRL_W   = 5;
    localparam int EX_MEM_DATA_W  = 97;
    localparam int EX_MEM_CTRL_W  = 5;
    localparam int MEM_WB_DATA_W  = 64;
    localparam int MEM_WB_CTRL_W  = 5;

    localparam int DATA_W_DEF = 97;
    localparam int CTRL_W_DEF = 5;
    localparam int CNT_W_DEF  = 16;

    // Bit positions inside the control bundle.
    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMTOREG = 1;
    localparam int CTRL_MEMWRITE = 2;
    localparam int CTRL_ISBRANCH = 3;
    localparam int CTRL_ISJUMP   = 4;

endpackage

// File: rtl/pipe_slot.sv
// One storage entry (data + control) with load and clear enables.
// Latency: 1 cycle from load_i to outputs.
// Backpressure: none; the owner decides when to load or clear.
module pipe_slot #(
    parameter int DATA_W = 97,
    parameter int CTRL_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic [DATA_W-1:0] data_o,
    output logic [CTRL_W-1:0] ctrl_o
);

    logic [DATA_W-1:0] data_q;
    logic [CTRL_W-1:0] ctrl_q;

    // Entry register: reset and clear zero it (empty slot carries a NOP), load captures.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            data_q <= '0;
            ctrl_q <= '0;
        end else if (clear_i) begin
            data_q <= '0;
            ctrl_q <= '0;
        end else if (load_i) begin
            data_q <= data_i;
            ctrl_q <= ctrl_i;
        end
    end

    assign data_o = data_q;
    assign ctrl_o = ctrl_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready, flush and a one-entry skid slot.
// Latency: 1 cycle in->out; full throughput while downstream is ready.
// Backpressure: in_ready_o is registered (low only when skid is full); optional stall
// counter enabled by macro PIPE_STAGE_STALL_CNT_EN.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    state_t state_q, state_d;
    logic   in_ready_q;
    logic   in_xfer, out_xfer;

    logic   main_load, main_clr, main_from_skid;
    logic   skid_load, skid_clr;

    logic [DATA_W-1:0] main_data_d, skid_data_q;
    logic [CTRL_W-1:0] main_ctrl_d, skid_ctrl_q;

    assign out_valid_o = (state_q != ST_EMPTY);
    assign in_ready_o  = in_ready_q;
    assign in_xfer     = in_valid_i & in_ready_q;
    assign out_xfer    = out_valid_o & out_ready_i;

    // State register; in_ready is precomputed from the next state so it never depends on out_ready_i combinationally.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_TWO);
        end
    end

    // Next-state: flush empties the stage, otherwise track occupancy from the two handshakes.
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (in_xfer) state_d = ST_ONE;
                ST_ONE: begin
                    if (out_xfer && !in_xfer)      state_d = ST_EMPTY;
                    else if (in_xfer && !out_xfer) state_d = ST_TWO;
                end
                ST_TWO:   if (out_xfer) state_d = ST_ONE;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    // Slot controls: main is only rewritten when its entry leaves or the stage is empty, keeping outputs stable under stall.
    always_comb begin
        main_load      = 1'b0;
        main_clr       = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clr       = 1'b0;
        if (flush_i) begin
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: main_load = in_xfer;
                ST_ONE: begin
                    if (in_xfer && out_xfer) main_load = 1'b1;
                    else if (out_xfer)       main_clr  = 1'b1;
                    else if (in_xfer)        skid_load = 1'b1;
                end
                ST_TWO: begin
                    if (out_xfer) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clr       = 1'b1;
                    end
                end
                default: begin
                    main_clr = 1'b1;
                    skid_clr = 1'b1;
                end
            endcase
        end
    end

    assign main_data_d = main_from_skid ? skid_data_q : in_data_i;
    assign main_ctrl_d = main_from_skid ? skid_ctrl_q : in_ctrl_i;

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .load_i  (main_load),
        .clear_i (main_clr),
        .data_i  (main_data_d),
        .ctrl_i  (main_ctrl_d),
        .data_o  (out_data_o),
        .ctrl_o  (out_ctrl_o)
    );

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .load_i  (skid_load),
        .clear_i (skid_clr),
        .data_i  (in_data_i),
        .ctrl_i  (in_ctrl_i),
        .data_o  (skid_data_q),
        .ctrl_o  (skid_ctrl_q)
    );

`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Stall counter next value: count cycles where a valid entry is blocked, saturating at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid_o && !out_ready_i && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    // Stall counter register; only reset clears it, flush leaves it alone.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) stall_cnt_q <= '0;
        else          stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and scoreboarded bench for pipe_stage_reg.
// Latency: n/a.
// Backpressure: drives out_ready_i low to exercise stall and skid paths.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int DATA_W = EX_MEM_DATA_W;
    localparam int CTRL_W = EX_MEM_CTRL_W;
`ifdef PIPE_STAGE_STALL_CNT_EN
    localparam int CNT_W  = 4;
`else
    localparam int CNT_W  = 16;
`endif

    logic              clk = 1'b0;
    logic              rst_n_i, flush_i, in_valid_i, out_ready_i;
    logic              in_ready_o, out_valid_o;
    logic [DATA_W-1:0] in_data_i, out_data_o;
    logic [CTRL_W-1:0] in_ctrl_i, out_ctrl_o;
    logic [CNT_W-1:0]  stall_cnt_o;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .in_ctrl_i   (in_ctrl_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_ctrl_o  (out_ctrl_o),
        .stall_cnt_o (stall_cnt_o)
    );

    function automatic logic [DATA_W-1:0] mk_data(input int v);
        logic [DATA_W-1:0] d;
        d = DATA_W'(v);
        return (d << 64) | (d << 32) | d;
    endfunction

    function automatic logic [CTRL_W-1:0] mk_ctrl(input int v);
        logic [CTRL_W-1:0] c;
        c = CTRL_W'(v);
        return c | (CTRL_W'(1) << CTRL_REGWRITE);
    endfunction

    // Advance one edge and settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int v);
        in_valid_i = 1'b1;
        in_data_i  = mk_data(v);
        in_ctrl_i  = mk_ctrl(v);
    endtask

    task automatic idle_in();
        in_valid_i = 1'b0;
        in_data_i  = '0;
        in_ctrl_i  = '0;
    endtask

    task automatic do_reset();
        rst_n_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b0;
        push(99);
        tick(); tick();
        rst_n_i = 1'b1;
        idle_in();
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (out_valid_o !== 1'b0) begin failed++; $display("FAIL reset_valid got=%0b exp=0", out_valid_o); end
        tests++;
        if (out_ctrl_o !== '0) begin failed++; $display("FAIL reset_ctrl got=%0h exp=0", out_ctrl_o); end
        tests++;
        if (out_data_o !== '0) begin failed++; $display("FAIL reset_data got=%0h exp=0", out_data_o); end
        tests++;
        if (in_ready_o !== 1'b1) begin failed++; $display("FAIL reset_ready got=%0b exp=1", in_ready_o); end
        tests++;
        if (stall_cnt_o !== '0) begin failed++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt_o); end
    endtask

    task automatic test_streaming();
        out_ready_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            push(i);
            tick();
            tests++;
            if (out_valid_o !== 1'b1 || out_data_o !== mk_data(i) || out_ctrl_o !== mk_ctrl(i)) begin
                failed++;
                $display("FAIL stream_%0d valid=%0b data=%0h ctrl=%0h exp data=%0h ctrl=%0h",
                         i, out_valid_o, out_data_o, out_ctrl_o, mk_data(i), mk_ctrl(i));
            end
            tests++;
            if (in_ready_o !== 1'b1) begin failed++; $display("FAIL stream_ready_%0d got=%0b exp=1", i, in_ready_o); end
        end
        idle_in();
        tick();
        tests++;
        if (out_valid_o !== 1'b0 || out_ctrl_o !== '0) begin
            failed++;
            $display("FAIL stream_drain valid=%0b ctrl=%0h exp 0/0", out_valid_o, out_ctrl_o);
        end
    endtask

    task automatic test_stall();
        out_ready_i = 1'b0;
        push(16'hA);
        tick();
        tests++;
        if (in_ready_o !== 1'b1 || out_data_o !== mk_data(16'hA)) begin
            failed++; $display("FAIL stall_a ready=%0b data=%0h exp 1/%0h", in_ready_o, out_data_o, mk_data(16'hA));
        end
        push(16'hB);
        tick();
        idle_in();
        tests++;
        if (in_ready_o !== 1'b0) begin failed++; $display("FAIL stall_full_ready got=%0b exp=0", in_ready_o); end
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (out_valid_o !== 1'b1 || out_data_o !== mk_data(16'hA) || out_ctrl_o !== mk_ctrl(16'hA)) begin
                failed++; $display("FAIL stall_hold_%0d valid=%0b data=%0h exp 1/%0h", k, out_valid_o, out_data_o, mk_data(16'hA));
            end
            tick();
        end
        out_ready_i = 1'b1;
        tick();
        tests++;
        if (out_valid_o !== 1'b1 || out_data_o !== mk_data(16'hB) || out_ctrl_o !== mk_ctrl(16'hB)) begin
            failed++; $display("FAIL stall_b valid=%0b data=%0h exp 1/%0h", out_valid_o, out_data_o, mk_data(16'hB));
        end
        tests++;
        if (in_ready_o !== 1'b1) begin failed++; $display("FAIL stall_ready_back got=%0b exp=1", in_ready_o); end
        tick();
        tests++;
        if (out_valid_o !== 1'b0) begin failed++; $display("FAIL stall_empty got=%0b exp=0", out_valid_o); end
`ifndef PIPE_STAGE_STALL_CNT_EN
        tests++;
        if (stall_cnt_o !== '0) begin failed++; $display("FAIL cnt_tied got=%0d exp=0", stall_cnt_o); end
`endif
    endtask

    task automatic test_flush();
        out_ready_i = 1'b0;
        push(16'hC); tick();
        push(16'hD); tick();
        tests++;
        if (in_ready_o !== 1'b0) begin failed++; $display("FAIL flush_pre_full got=%0b exp=0", in_ready_o); end
        flush_i = 1'b1;
        push(16'hE);
        tick();
        flush_i = 1'b0;
        idle_in();
        tests++;
        if (out_valid_o !== 1'b0 || out_ctrl_o !== '0 || in_ready_o !== 1'b1) begin
            failed++; $display("FAIL flush_state valid=%0b ctrl=%0h ready=%0b exp 0/0/1", out_valid_o, out_ctrl_o, in_ready_o);
        end
        out_ready_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            tests++;
            if (out_valid_o !== 1'b0) begin failed++; $display("FAIL flush_lost_%0d valid=%0b exp=0", k, out_valid_o); end
        end
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] q_d[$];
        logic [CTRL_W-1:0] q_c[$];
        int next_v = 1000;
        int bad = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            in_valid_i  = ($urandom_range(0, 3) != 0);
            out_ready_i = ($urandom_range(0, 2) != 0);
            if (cyc >= 2980) in_valid_i = 1'b0;
            in_data_i = mk_data(next_v);
            in_ctrl_i = mk_ctrl(next_v);
            #1;
            if (out_valid_o && out_ready_i) begin
                tests++;
                if (q_d.size() == 0) begin
                    failed++; bad++;
                    if (bad < 5) $display("FAIL rand_dup data=%0h exp none", out_data_o);
                end else begin
                    if (out_data_o !== q_d[0] || out_ctrl_o !== q_c[0]) begin
                        failed++; bad++;
                        if (bad < 5) $display("FAIL rand_order data=%0h ctrl=%0h exp %0h/%0h", out_data_o, out_ctrl_o, q_d[0], q_c[0]);
                    end
                    void'(q_d.pop_front());
                    void'(q_c.pop_front());
                end
            end
            if (in_valid_i && in_ready_o) begin
                q_d.push_back(in_data_i);
                q_c.push_back(in_ctrl_i);
                next_v++;
            end
            tick();
            tests++;
            if (out_valid_o !== (q_d.size() != 0) || (!out_valid_o && out_ctrl_o !== '0)) begin
                failed++; bad++;
                if (bad < 5) $display("FAIL rand_valid got=%0b ctrl=%0h exp valid=%0b", out_valid_o, out_ctrl_o, q_d.size() != 0);
            end
        end
        idle_in();
        tests++;
        if (q_d.size() != 0) begin failed++; $display("FAIL rand_left got=%0d exp=0", q_d.size()); end
    endtask

`ifdef PIPE_STAGE_STALL_CNT_EN
    task automatic test_stall_cnt();
        do_reset();
        out_ready_i = 1'b0;
        push(7);
        tick();
        idle_in();
        // First stalled edge is the one after the entry becomes visible.
        for (int k = 0; k < 20; k++) tick();
        tests++;
        if (stall_cnt_o !== 4'd15) begin failed++; $display("FAIL cnt_sat got=%0d exp=15", stall_cnt_o); end
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        tick();
        tests++;
        if (stall_cnt_o !== 4'd15) begin failed++; $display("FAIL cnt_flush got=%0d exp=15", stall_cnt_o); end
    endtask
`endif

    initial begin
        rst_n_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b0;
        idle_in();
        test_reset();
        test_streaming();
        test_stall();
        test_flush();
        test_random();
`ifdef PIPE_STAGE_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
